// File: rtl/program_loader_pkg.sv
// Shared loader definitions: state encodings, status helper and build-wide width defaults.
// Optional readback check is enabled by defining PROGRAM_LOADER_VERIFY_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef INSTRUCTION_BASE
`define INSTRUCTION_BASE 512
`endif
`ifndef MEM_DEPTH
`define MEM_DEPTH 4096
`endif

package program_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE    = 3'd0,
    LDR_LOAD    = 3'd1,
    LDR_VERIFY  = 3'd2,
    LDR_RELEASE = 3'd3,
    LDR_KICK    = 3'd4,
    LDR_DONE    = 3'd5,
    LDR_ERR     = 3'd6
  } ldr_state_t;

  function automatic logic ldr_is_busy(input ldr_state_t s);
    return s inside {LDR_LOAD, LDR_VERIFY, LDR_RELEASE, LDR_KICK};
  endfunction

endpackage

// File: rtl/program_loader_byte_checksum.sv
// Running modulo-2^W byte sum with synchronous clear; present only when
// PROGRAM_LOADER_VERIFY_EN is defined.
`ifdef PROGRAM_LOADER_VERIFY_EN
module byte_checksum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         add_en,
  input  logic [W-1:0] data,
  output logic [W-1:0] sum
);

  logic [W-1:0] sum_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_reg <= '0;
    end else if (clear) begin
      sum_reg <= '0;
    end else if (add_en) begin
      sum_reg <= sum_reg + data;
    end
  end

  assign sum = sum_reg;

endmodule
`endif

// File: rtl/program_loader.sv
// Streams a program into instruction memory with the core held in reset, then releases and kicks it.
// Define PROGRAM_LOADER_VERIFY_EN to add a checksum readback pass before release.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int REG_WIDTH  = `REG_WIDTH,
  parameter int BASE       = `INSTRUCTION_BASE,
  parameter int DEPTH      = `MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [REG_WIDTH-1:0]  byte_data,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_din,
  output logic                  mem_we,
  input  logic [REG_WIDTH-1:0]  mem_dout,
  output logic                  manual_mem,
  output logic                  core_reset_n,
  output logic                  trigger_program,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] count
);

  localparam int CAP = DEPTH - BASE;
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(CAP - 1);

  ldr_state_t state_reg, state_next;
  logic [ADDR_WIDTH-1:0] count_reg, count_next;
  logic released_reg;
  logic accept;
  logic session_start;

  assign accept        = (state_reg == LDR_LOAD) && byte_valid;
  assign session_start = start && (state_reg inside {LDR_IDLE, LDR_DONE, LDR_ERR});

`ifdef PROGRAM_LOADER_VERIFY_EN
  logic [ADDR_WIDTH-1:0] verify_idx_reg;
  logic [REG_WIDTH-1:0]  load_sum_reg;
  logic [REG_WIDTH-1:0]  sum;
  logic [REG_WIDTH-1:0]  final_sum;
  logic                  in_verify;
  logic                  verify_last;
  logic                  ck_clear;
  logic                  ck_add;
  logic [REG_WIDTH-1:0]  ck_data;

  // Readback data lags the address by one cycle, so index 0 only clears and the
  // final cycle folds in the last byte combinationally before comparing.
  assign in_verify   = (state_reg == LDR_VERIFY);
  assign verify_last = in_verify && (verify_idx_reg == count_reg);
  assign final_sum   = sum + mem_dout;
  assign ck_clear    = session_start || (in_verify && (verify_idx_reg == '0));
  assign ck_add      = accept || (in_verify && (verify_idx_reg != '0));
  assign ck_data     = in_verify ? mem_dout : byte_data;

  byte_checksum #(.W(REG_WIDTH)) u_checksum (
    .clk    (clk),
    .reset  (reset),
    .clear  (ck_clear),
    .add_en (ck_add),
    .data   (ck_data),
    .sum    (sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      verify_idx_reg <= '0;
      load_sum_reg   <= '0;
    end else begin
      verify_idx_reg <= in_verify ? verify_idx_reg + ADDR_WIDTH'(1) : '0;
      if (in_verify && (verify_idx_reg == '0)) begin
        load_sum_reg <= sum;
      end
    end
  end
`else
  logic unused_dout;
  assign unused_dout = ^mem_dout;
`endif

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      LDR_IDLE, LDR_DONE, LDR_ERR: begin
        if (start) begin
          state_next = LDR_LOAD;
          count_next = '0;
        end
      end
      LDR_LOAD: begin
        if (accept) begin
          count_next = count_reg + ADDR_WIDTH'(1);
          if (byte_last) begin
`ifdef PROGRAM_LOADER_VERIFY_EN
            state_next = LDR_VERIFY;
`else
            state_next = LDR_RELEASE;
`endif
          end else if (count_reg == LAST_IDX) begin
            state_next = LDR_ERR;
          end
        end
      end
`ifdef PROGRAM_LOADER_VERIFY_EN
      LDR_VERIFY: begin
        if (verify_last) begin
          state_next = (final_sum == load_sum_reg) ? LDR_RELEASE : LDR_ERR;
        end
      end
`endif
      LDR_RELEASE: state_next = LDR_KICK;
      LDR_KICK:    state_next = LDR_DONE;
      default:     state_next = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= LDR_IDLE;
      count_reg    <= '0;
      released_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      released_reg <= state_next inside {LDR_RELEASE, LDR_KICK, LDR_DONE};
    end
  end

  // Memory port: write path is combinational from the handshake so it lands on the accepting edge.
  always_comb begin
    mem_addr = BASE_A;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (state_reg == LDR_LOAD) begin
      mem_addr = BASE_A + count_reg;
      mem_din  = byte_data;
      mem_we   = byte_valid;
    end
`ifdef PROGRAM_LOADER_VERIFY_EN
    if (state_reg == LDR_VERIFY) begin
      mem_addr = BASE_A + verify_idx_reg;
    end
`endif
  end

  assign byte_ready      = (state_reg == LDR_LOAD);
  assign manual_mem      = !released_reg;
  assign core_reset_n    = released_reg;
  assign trigger_program = (state_reg == LDR_KICK);
  assign busy            = ldr_is_busy(state_reg);
  assign done            = (state_reg == LDR_DONE);
  assign error           = (state_reg == LDR_ERR);
  assign count           = count_reg;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued by the stimulus
// and popped by a write monitor; status vectors are compared at fixed points.
module tb_program_loader;

  localparam int AW    = 8;
  localparam int RW    = 8;
  localparam int BASE  = 4;
  localparam int DEPTH = 16;
  localparam int CAP   = DEPTH - BASE;

  // status = {busy, done, error, manual_mem, core_reset_n, trigger_program, byte_ready}
  localparam logic [6:0] ST_RESET   = 7'b0001000;
  localparam logic [6:0] ST_LOAD    = 7'b1001001;
  localparam logic [6:0] ST_RELEASE = 7'b1000100;
  localparam logic [6:0] ST_KICK    = 7'b1000110;
  localparam logic [6:0] ST_DONE    = 7'b0100100;
  localparam logic [6:0] ST_ERR     = 7'b0011000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [RW-1:0] byte_data = '0;
  logic          byte_last = 1'b0;
  logic          byte_ready;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_din;
  logic          mem_we;
  logic [RW-1:0] mem_dout;
  logic          manual_mem, core_reset_n, trigger_program, busy, done, error;
  logic [AW-1:0] count;

  program_loader #(.ADDR_WIDTH(AW), .REG_WIDTH(RW), .BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .manual_mem(manual_mem), .core_reset_n(core_reset_n), .trigger_program(trigger_program),
    .busy(busy), .done(done), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int trig_count = 0;
  int exp_cnt = 0;
  int t0;
  logic [15:0] exp_q[$];
  logic [7:0] prog [5] = '{8'hA9, 8'h05, 8'h85, 8'h10, 8'h00};

  // Memory model: write on edge, registered read, optional corruption of BASE+2 reads.
  logic [7:0] mem_model [DEPTH];
  logic [7:0] rd_q;
  logic [AW-1:0] rd_addr_q;
  logic clear_mem = 1'b0;
  logic corrupt = 1'b0;

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < DEPTH; i++) mem_model[i] <= 8'h00;
    end else if (mem_we && (mem_addr < AW'(DEPTH))) begin
      mem_model[mem_addr[3:0]] <= mem_din;
    end
    rd_q      <= (mem_addr < AW'(DEPTH)) ? mem_model[mem_addr[3:0]] : 8'h00;
    rd_addr_q <= mem_addr;
  end

  assign mem_dout = rd_q ^ ((corrupt && (rd_addr_q == AW'(BASE + 2))) ? 8'hFF : 8'h00);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  function automatic logic [6:0] st();
    return {busy, done, error, manual_mem, core_reset_n, trigger_program, byte_ready};
  endfunction

  // Write monitor: every presented write must match the head of the expected queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL write_unexpected actual=%h:%h expected=none", mem_addr, mem_din);
      end else begin
        check("write", {16'h0, mem_addr, mem_din}, {16'h0, exp_q.pop_front()});
      end
    end
    if (trigger_program === 1'b1) trig_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit expect_clear);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (expect_clear) exp_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input bit gap);
    exp_q.push_back({8'(BASE + exp_cnt), d});
    exp_cnt++;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = last;
    tick();
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    if (gap) tick();
  endtask

  task automatic wipe_mem();
    clear_mem = 1'b1;
    tick();
    clear_mem = 1'b0;
  endtask

  task automatic send_prog(input bit gap);
    for (int i = 0; i < 5; i++) send_byte(prog[i], (i == 4), gap);
  endtask

  // Called right after the edge that accepted the last byte.
  task automatic finish_session(input string name, input bit exp_ok);
`ifdef PROGRAM_LOADER_VERIFY_EN
    int n = 0;
    while (!(done || error) && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d cycles expected=<64", name, n);
    end
    check({name, "_final"}, 32'(st()), exp_ok ? 32'(ST_DONE) : 32'(ST_ERR));
`else
    check({name, "_release"}, 32'(st()), 32'(ST_RELEASE));
    tick();
    check({name, "_kick"}, 32'(st()), 32'(ST_KICK));
    tick();
    check({name, "_done"}, 32'(st()), exp_ok ? 32'(ST_DONE) : 32'(ST_ERR));
`endif
  endtask

  task automatic check_image(input string name);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_img%0d", name, i), 32'(mem_model[BASE + i]), 32'(prog[i]));
  endtask

  initial begin
    reset = 1'b1;
    wipe_mem();
    tick();
    check("reset_status", 32'(st()), 32'(ST_RESET));
    check("reset_port", {8'h0, mem_addr, mem_din, 7'h0, mem_we}, {8'h0, 8'(BASE), 8'h00, 8'h00});
    check("reset_count", 32'(count), 32'd0);
    reset = 1'b0;
    tick();

    // Plain back-to-back load
    pulse_start(1);
    check("t1_load", 32'(st()), 32'(ST_LOAD));
    t0 = trig_count;
    send_prog(0);
    finish_session("t1", 1);
    check("t1_count", 32'(count), 32'd5);
    check("t1_trig", 32'(trig_count - t0), 32'd1);
    check_image("t1");

    // Same program with valid toggling
    wipe_mem();
    pulse_start(1);
    t0 = trig_count;
    send_byte(prog[0], 1'b0, 1);
    send_byte(prog[1], 1'b0, 1);
    send_byte(prog[2], 1'b0, 1);
    send_byte(prog[3], 1'b0, 1);
    send_byte(prog[4], 1'b1, 0);
    finish_session("t2", 1);
    check("t2_count", 32'(count), 32'd5);
    check("t2_trig", 32'(trig_count - t0), 32'd1);
    check_image("t2");

    // Overflow: CAP bytes with no last
    pulse_start(1);
    t0 = trig_count;
    for (int i = 0; i < CAP; i++) send_byte(8'(8'h30 + i), 1'b0, 0);
    check("ovf_status", 32'(st()), 32'(ST_ERR));
    check("ovf_count", 32'(count), 32'(CAP));
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    tick();
    tick();
    byte_valid = 1'b0;
    check("ovf_trig", 32'(trig_count - t0), 32'd0);
    check("ovf_status_hold", 32'(st()), 32'(ST_ERR));

    // Reset mid-session, then clean reload
    wipe_mem();
    pulse_start(1);
    for (int i = 0; i < 3; i++) send_byte(prog[i], 1'b0, 0);
    reset = 1'b1;
    #1;
    check("rst_status", 32'(st()), 32'(ST_RESET));
    check("rst_port", {8'h0, mem_addr, mem_din, 7'h0, mem_we}, {8'h0, 8'(BASE), 8'h00, 8'h00});
    check("rst_count", 32'(count), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    wipe_mem();
    pulse_start(1);
    t0 = trig_count;
    send_prog(0);
    finish_session("rst_reload", 1);
    check("rst_reload_trig", 32'(trig_count - t0), 32'd1);
    check_image("rst_reload");

    // start during LOAD is ignored
    wipe_mem();
    pulse_start(1);
    send_byte(prog[0], 1'b0, 0);
    send_byte(prog[1], 1'b0, 0);
    pulse_start(0);
    check("ign_status", 32'(st()), 32'(ST_LOAD));
    check("ign_count", 32'(count), 32'd2);
    send_byte(prog[2], 1'b0, 0);
    send_byte(prog[3], 1'b0, 0);
    send_byte(prog[4], 1'b1, 0);
    finish_session("ign", 1);
    check("ign_final_count", 32'(count), 32'd5);
    check_image("ign");

`ifdef PROGRAM_LOADER_VERIFY_EN
    // Corrupted readback must block the core
    wipe_mem();
    corrupt = 1'b1;
    pulse_start(1);
    t0 = trig_count;
    send_prog(0);
    finish_session("vfy_bad", 0);
    check("vfy_bad_trig", 32'(trig_count - t0), 32'd0);
    corrupt = 1'b0;
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
